// File: rtl/ascon_pkg.sv
// Shared Ascon types and round constants used by the permutation sequencer and its datapath.
package ascon_pkg;

    // Five 64-bit words, x0 at index 0 through x4 at index 4.
    typedef logic [4:0][63:0] t_state_array;

    localparam logic [7:0] ROUND_CONSTANTS [12] = '{
        8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
    };

endpackage

// File: rtl/permutation_sequencer.sv
// Ascon permutation controller: holds the 320-bit state and steps the round index while
// an external combinational round datapath is looped back into the state register.
module permutation_sequencer
    import ascon_pkg::*;
#(
    parameter int MAX_ROUNDS = $size(ROUND_CONSTANTS)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [3:0]   i_rounds,
    input  t_state_array i_state,
    input  t_state_array i_round_state,
    output logic [3:0]   o_round,
    output t_state_array o_state,
    output logic         o_ready,
    output logic         o_busy,
    output logic         o_done
);

    localparam logic [3:0] MAX_N = 4'(MAX_ROUNDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t       fsm;
    logic [3:0] remaining;
    logic [3:0] rounds_n;

    // Out-of-range round requests fall back to the full permutation.
    always_comb begin
        rounds_n = i_rounds;
        if (i_rounds == 4'd0 || i_rounds > MAX_N) begin
            rounds_n = MAX_N;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fsm       <= IDLE;
            o_state   <= '0;
            o_round   <= '0;
            remaining <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (i_start) begin
                        o_state   <= i_state;
                        o_round   <= MAX_N - rounds_n;
                        remaining <= rounds_n;
                        fsm       <= RUN;
                    end
                end
                RUN: begin
                    o_state   <= i_round_state;
                    remaining <= remaining - 4'd1;
                    // Last round keeps its index so o_round never passes MAX_ROUNDS-1.
                    if (remaining == 4'd1) begin
                        fsm <= DONE;
                    end else begin
                        o_round <= o_round + 4'd1;
                    end
                end
                DONE: begin
                    fsm <= IDLE;
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

    assign o_ready = (fsm == IDLE);
    assign o_busy  = (fsm == RUN);
    assign o_done  = (fsm == DONE);

endmodule

// File: tb/tb_permutation_sequencer.sv
// Self-checking bench for permutation_sequencer with a constant-addition-only round model.
module tb_permutation_sequencer;
    import ascon_pkg::*;

    localparam logic [7:0] RC [12] = '{
        8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
    };

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   rounds;
    t_state_array init;
    t_state_array round_state;
    logic [3:0]   round;
    t_state_array state;
    logic         ready, busy, done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int cyc = 0;
    t_state_array exp_q [$];
    t_state_array exp_final;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    permutation_sequencer #(.MAX_ROUNDS(12)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_start(start),
        .i_rounds(rounds),
        .i_state(init),
        .i_round_state(round_state),
        .o_round(round),
        .o_state(state),
        .o_ready(ready),
        .o_busy(busy),
        .o_done(done)
    );

    // Round datapath model: only x2 ^= round constant.
    always_comb begin
        round_state = state;
        if (round < 4'd12) begin
            round_state[2] = state[2] ^ {56'd0, RC[round]};
        end
    end

    function automatic t_state_array expect_final(input t_state_array s, input int n);
        t_state_array r = s;
        for (int i = 12 - n; i < 12; i++) r[2][7:0] = r[2][7:0] ^ RC[i];
        return r;
    endfunction

    function automatic t_state_array make_state(input logic [63:0] x2);
        t_state_array s;
        s[0] = 64'h80400C0600000000;
        s[1] = 64'hDEADBEEFCAFEF00D;
        s[2] = x2;
        s[3] = 64'h1122334455667788;
        s[4] = 64'hA5A5A5A55A5A5A5A;
        return s;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: o_done high at cycle %0d with no run outstanding", cyc);
            end else begin
                exp_final = exp_q.pop_front();
                if (state !== exp_final) begin
                    errors++;
                    $display("FAIL done_state: got %h required %h", state, exp_final);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rounds = 4'd12; init = make_state(64'hFFFF);
        repeat (3) @(negedge clk);
        checks++;
        if ({ready, busy, done} !== 3'b100 || round !== 4'd0 || state !== '0) begin
            errors++;
            $display("FAIL reset_state: rdy/bsy/dn=%b round=%0d state=%h required 100 0 0",
                     {ready, busy, done}, round, state);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({ready, busy, done} !== 3'b100 || state !== '0) begin
            errors++;
            $display("FAIL reset_idle_hold: rdy/bsy/dn=%b state=%h required 100 0", {ready, busy, done}, state);
        end
    endtask

    task automatic test_run_length(input logic [3:0] r, input int n, input logic [63:0] x2, input string tag);
        t_state_array s = make_state(x2);
        t_state_array cur = s;
        start = 1'b1; init = s; rounds = r;
        exp_q.push_back(expect_final(s, n));
        @(negedge clk);
        start = 1'b0; init = ~s; rounds = 4'($urandom_range(1, 15));
        for (int c = 0; c < n; c++) begin
            checks++;
            if (busy !== 1'b1 || round !== 4'(12 - n + c) || state !== cur) begin
                errors++;
                $display("FAIL %s_run_c%0d: busy=%b round=%0d state=%h required 1 %0d %h",
                         tag, c, busy, round, state, 12 - n + c, cur);
            end
            cur[2][7:0] = cur[2][7:0] ^ RC[12 - n + c];
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || round !== 4'd11) begin
            errors++;
            $display("FAIL %s_done: done=%b busy=%b round=%0d required 1 0 11", tag, done, busy, round);
        end
        @(negedge clk);
        checks++;
        if ({ready, busy, done} !== 3'b100 || state !== cur) begin
            errors++;
            $display("FAIL %s_after: rdy/bsy/dn=%b state=%h required 100 %h", tag, {ready, busy, done}, state, cur);
        end
    endtask

    task automatic test_ignore_start();
        t_state_array s = make_state(64'h0F0F);
        int base = done_cnt;
        start = 1'b1; init = s; rounds = 4'd8;
        exp_q.push_back(expect_final(s, 8));
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            start = (c == 3); init = make_state(64'hBAD); rounds = 4'd2;
            checks++;
            if (busy !== 1'b1 || round !== 4'(4 + c)) begin
                errors++;
                $display("FAIL ignore_run_c%0d: busy=%b round=%0d required 1 %0d", c, busy, round, 4 + c);
            end
            @(negedge clk);
        end
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || done_cnt != base + 1) begin
            errors++;
            $display("FAIL ignore_after_done: ready=%b dones=%0d required 1 %0d", ready, done_cnt - base, 1);
        end
        s = make_state(64'h1234);
        init = s; rounds = 4'd4;
        exp_q.push_back(expect_final(s, 4));
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (busy !== 1'b1 || round !== 4'(8 + c)) begin
                errors++;
                $display("FAIL ignore_restart_c%0d: busy=%b round=%0d required 1 %0d", c, busy, round, 8 + c);
            end
            @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (done_cnt != base + 2 || ready !== 1'b1) begin
            errors++;
            $display("FAIL ignore_done_count: dones=%0d ready=%b required 2 1", done_cnt - base, ready);
        end
    endtask

    task automatic test_midrun_reset();
        int base = done_cnt;
        start = 1'b1; init = make_state(64'h5555); rounds = 4'd12;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) rst = 1'b1;
            if (c < 3) @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if ({ready, busy, done} !== 3'b100 || state !== '0 || round !== 4'd0) begin
            errors++;
            $display("FAIL midrun_reset: rdy/bsy/dn=%b round=%0d state=%h required 100 0 0",
                     {ready, busy, done}, round, state);
        end
        rst = 1'b0;
        repeat (14) @(negedge clk);
        checks++;
        if (done_cnt != base || ready !== 1'b1) begin
            errors++;
            $display("FAIL midrun_no_done: dones=%0d ready=%b required 0 1", done_cnt - base, ready);
        end
    endtask

    task automatic test_back_to_back();
        t_state_array s = make_state(64'h00C0FFEE);
        int last_done = 0;
        start = 1'b1; init = s; rounds = 4'd8;
        for (int r = 0; r < 3; r++) begin
            exp_q.push_back(expect_final(s, 8));
            @(negedge clk);
            for (int c = 0; c < 8; c++) begin
                checks++;
                if (busy !== 1'b1 || round !== 4'(4 + c)) begin
                    errors++;
                    $display("FAIL b2b_r%0d_c%0d: busy=%b round=%0d required 1 %0d", r, c, busy, round, 4 + c);
                end
                @(negedge clk);
            end
            checks++;
            if (done !== 1'b1 || (r > 0 && cyc - last_done != 10)) begin
                errors++;
                $display("FAIL b2b_period_r%0d: done=%b period=%0d required 1 10", r, done, cyc - last_done);
            end
            last_done = cyc;
            @(negedge clk);
            checks++;
            if (ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready_r%0d: ready=%b required 1", r, ready);
            end
            if (r == 2) start = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_run_length(4'd12, 12, 64'h0123456789ABCDEF, "full12");
        test_run_length(4'd6, 6, 64'h0, "six");
        test_run_length(4'd0, 12, 64'h0123456789ABCDEF, "clamp0");
        test_run_length(4'd15, 12, 64'h0123456789ABCDEF, "clamp15");
        test_run_length(4'd1, 1, 64'h42, "one");
        test_ignore_start();
        test_midrun_reset();
        test_run_length(4'd12, 12, 64'hFEDCBA9876543210, "after_reset");
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
